// File: rtl/axis_block_packer.sv
// Packs IN_WIDTH-bit AXI-Stream words into OUT_WIDTH-bit blocks, word 0 in the MSBs.
// Define AXIS_PACKER_BSWAP_EN to byte-reverse each input word before packing.
module axis_block_packer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 128,
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [OUT_WIDTH-1:0] m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast,
    output logic                 short_pkt
);

    localparam int unsigned WORDS = OUT_WIDTH / IN_WIDTH;

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic                 last_q, last_d;
    logic                 short_q, short_d;
    logic [IN_WIDTH-1:0]  word_in;

    always_comb begin
        word_in = s_axis_tdata;
`ifdef AXIS_PACKER_BSWAP_EN
        for (int unsigned b = 0; b < IN_WIDTH / 8; b++) begin
            word_in[b*8 +: 8] = s_axis_tdata[IN_WIDTH-8-b*8 +: 8];
        end
`endif
    end

    // Handshake outputs decode only the registered state, so the FIFO's tready can
    // depend combinationally on m_tvalid without forming a loop.
    assign s_axis_tready = (state_q == FILL);
    assign m_tvalid      = (state_q == HOLD);
    assign m_tdata       = data_q;
    assign m_tlast       = last_q;
    assign short_pkt     = short_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        last_d  = last_q;
        short_d = 1'b0;
        case (state_q)
            FILL: begin
                if (s_axis_tvalid) begin
                    for (int unsigned i = 0; i < WORDS; i++) begin
                        if (CNT_WIDTH'(i) == cnt_q) begin
                            data_d[OUT_WIDTH-1-i*IN_WIDTH -: IN_WIDTH] = word_in;
                        end else if (s_axis_tlast && (CNT_WIDTH'(i) > cnt_q)) begin
                            data_d[OUT_WIDTH-1-i*IN_WIDTH -: IN_WIDTH] = '0;
                        end
                    end
                    if (s_axis_tlast) begin
                        cnt_d   = '0;
                        last_d  = 1'b1;
                        short_d = (cnt_q != CNT_WIDTH'(WORDS - 1));
                        state_d = HOLD;
                    end else if (cnt_q == CNT_WIDTH'(WORDS - 1)) begin
                        cnt_d   = '0;
                        last_d  = 1'b0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (m_tready) begin
                    data_d  = '0;
                    last_d  = 1'b0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            last_q  <= last_d;
            short_q <= short_d;
        end
    end

endmodule
